// File: rtl/dtrig_threshold_scan_if.sv
// Bundles the DAC-loader handshake and the result stream of the L0
// threshold-scan sequencer. The master side is the sequencer and the slave
// side is the DAC loader plus the result consumer.
interface dtrig_threshold_scan_if #(
    parameter int NCH = 7
);
    logic [8*NCH-1:0] dtrig_threshold;
    logic             command_dacset;
    logic             command_dacset_finish;
    logic             dtrig_en;

    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_thr;
    logic [2:0]       res_ch;
    logic [15:0]      res_count;

    modport master (
        output dtrig_threshold,
        output command_dacset,
        input  command_dacset_finish,
        input  dtrig_en,
        output res_valid,
        input  res_ready,
        output res_thr,
        output res_ch,
        output res_count
    );

    modport slave (
        input  dtrig_threshold,
        input  command_dacset,
        output command_dacset_finish,
        output dtrig_en,
        input  res_valid,
        output res_ready,
        input  res_thr,
        input  res_ch,
        input  res_count
    );
endinterface

// File: rtl/dtrig_threshold_scan.sv
// L0 threshold-scan sequencer. Steps a common threshold across all channels,
// loads it through the DAC handshake, waits a settle time, counts trigger
// pulses per channel over a window, and streams one result per channel.
// After the last step (or an abort) the manual thresholds are reloaded.
// Optional macro DTRIG_SCAN_TIMEOUT_EN adds a per-phase DAC handshake
// timeout that ends the scan with scan_err set and no restore load.
module dtrig_threshold_scan #(
    parameter int NCH         = 7,
    parameter int SETTLE_MS   = 2,
    parameter int DAC_TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             msec,
    input  logic             scan_start,
    input  logic             scan_abort,
    input  logic [7:0]       thr_start,
    input  logic [7:0]       thr_stop,
    input  logic [7:0]       thr_step,
    input  logic [15:0]      scan_window_ms,
    input  logic [8*NCH-1:0] thr_manual,
    input  logic [NCH-1:0]   dtrig_trig,
    output logic             scan_busy,
    output logic             scan_done,
    output logic             scan_err,
    dtrig_threshold_scan_if.master bus
);

    localparam int              CHW         = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [15:0]     SETTLE_LAST = (SETTLE_MS > 1) ? 16'(SETTLE_MS - 1) : 16'd0;
    localparam logic [15:0]     TIMEOUT_LIM = 16'(DAC_TIMEOUT);
    localparam logic [CHW-1:0]  LAST_CH     = CHW'(NCH - 1);

`ifdef DTRIG_SCAN_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_DACREQ,
        S_DACACK,
        S_DACREL,
        S_SETTLE,
        S_COUNT,
        S_REPORT,
        S_NEXT,
        S_RESTORE,
        S_FINISH
    } state_t;

    state_t          state_q,   state_d;
    logic [7:0]      cur_thr_q, cur_thr_d;
    logic            restore_q, restore_d;
    logic [15:0]     ms_cnt_q,  ms_cnt_d;
    logic [CHW-1:0]  rpt_ch_q,  rpt_ch_d;
    logic [15:0]     to_cnt_q,  to_cnt_d;
    logic            err_q,     err_d;
    logic [15:0]     cnt_q [NCH];
    logic [15:0]     cnt_d [NCH];

    logic [8:0]      nxt;
    logic [15:0]     win_last;
    logic            dac_timeout;
    logic            abort_req;

    // Next-state logic: scan sequencing, settle/window timing, pulse counting and result stepping
    always_comb begin
        state_d   = state_q;
        cur_thr_d = cur_thr_q;
        restore_d = restore_q;
        ms_cnt_d  = ms_cnt_q;
        rpt_ch_d  = rpt_ch_q;
        to_cnt_d  = to_cnt_q;
        err_d     = err_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        nxt         = {1'b0, cur_thr_q} + {1'b0, thr_step};
        win_last    = (scan_window_ms == 16'd0) ? 16'd0 : scan_window_ms - 16'd1;
        dac_timeout = TIMEOUT_EN && (to_cnt_q == TIMEOUT_LIM);
        abort_req   = scan_abort && !restore_q &&
                      (state_q inside {S_DACREQ, S_DACACK, S_DACREL, S_SETTLE,
                                       S_COUNT, S_REPORT, S_NEXT});

        if (abort_req) begin
            state_d = S_RESTORE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (scan_start) begin
                        cur_thr_d = thr_start;
                        restore_d = 1'b0;
                        err_d     = 1'b0;
                        state_d   = S_DACREQ;
                    end
                end
                S_DACREQ: begin
                    to_cnt_d = 16'd0;
                    state_d  = S_DACACK;
                end
                S_DACACK: begin
                    if (bus.command_dacset_finish) begin
                        to_cnt_d = 16'd0;
                        state_d  = S_DACREL;
                    end else if (dac_timeout) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                end
                S_DACREL: begin
                    if (!bus.command_dacset_finish && bus.dtrig_en) begin
                        ms_cnt_d = 16'd0;
                        state_d  = restore_q ? S_FINISH : S_SETTLE;
                    end else if (dac_timeout) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (msec) begin
                        if (ms_cnt_q >= SETTLE_LAST) begin
                            ms_cnt_d = 16'd0;
                            for (int i = 0; i < NCH; i++) begin
                                cnt_d[i] = 16'd0;
                            end
                            state_d = S_COUNT;
                        end else begin
                            ms_cnt_d = ms_cnt_q + 16'd1;
                        end
                    end
                end
                S_COUNT: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (dtrig_trig[i] && (cnt_q[i] != 16'hFFFF)) begin
                            cnt_d[i] = cnt_q[i] + 16'd1;
                        end
                    end
                    if (msec) begin
                        if (ms_cnt_q >= win_last) begin
                            rpt_ch_d = '0;
                            state_d  = S_REPORT;
                        end else begin
                            ms_cnt_d = ms_cnt_q + 16'd1;
                        end
                    end
                end
                S_REPORT: begin
                    if (bus.res_ready) begin
                        if (rpt_ch_q == LAST_CH) begin
                            state_d = S_NEXT;
                        end else begin
                            rpt_ch_d = rpt_ch_q + 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    if ((thr_step == 8'd0) || (nxt > {1'b0, thr_stop}) || nxt[8]) begin
                        state_d = S_RESTORE;
                    end else begin
                        cur_thr_d = nxt[7:0];
                        state_d   = S_DACREQ;
                    end
                end
                S_RESTORE: begin
                    if (!bus.command_dacset_finish) begin
                        restore_d = 1'b1;
                        state_d   = S_DACREQ;
                    end
                end
                S_FINISH: begin
                    restore_d = 1'b0;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cur_thr_q <= 8'd0;
            restore_q <= 1'b0;
            ms_cnt_q  <= 16'd0;
            rpt_ch_q  <= '0;
            to_cnt_q  <= 16'd0;
            err_q     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= 16'd0;
            end
        end else begin
            state_q   <= state_d;
            cur_thr_q <= cur_thr_d;
            restore_q <= restore_d;
            ms_cnt_q  <= ms_cnt_d;
            rpt_ch_q  <= rpt_ch_d;
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Outputs decoded from the registered state; manual thresholds pass through outside scan steps
    always_comb begin
        bus.command_dacset = (state_q == S_DACREQ) || (state_q == S_DACACK);
        if (!restore_q && (state_q inside {S_DACREQ, S_DACACK, S_DACREL, S_SETTLE,
                                           S_COUNT, S_REPORT, S_NEXT})) begin
            bus.dtrig_threshold = {NCH{cur_thr_q}};
        end else begin
            bus.dtrig_threshold = thr_manual;
        end
        bus.res_valid = (state_q == S_REPORT);
        bus.res_thr   = cur_thr_q;
        bus.res_ch    = 3'(rpt_ch_q);
        bus.res_count = cnt_q[rpt_ch_q];
        scan_busy     = (state_q != S_IDLE);
        scan_done     = (state_q == S_FINISH);
        scan_err      = err_q;
    end

endmodule

// File: tb/tb_dtrig_threshold_scan.sv
// Self-checking bench for dtrig_threshold_scan. Stimulus pushes expected DAC
// loads and results into queues; monitors pop and compare when the DUT
// presents a load request or an accepted result. Honours the optional
// DTRIG_SCAN_TIMEOUT_EN macro with an extra timeout scenario.
module tb_dtrig_threshold_scan;

    localparam int NCH = 7;

    typedef struct {
        logic [7:0] thr;
        logic [2:0] ch;
        int         lo;
        int         hi;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             msec;
    logic             scan_start;
    logic             scan_abort;
    logic [7:0]       thr_start;
    logic [7:0]       thr_stop;
    logic [7:0]       thr_step;
    logic [15:0]      scan_window_ms;
    logic [8*NCH-1:0] thr_manual;
    logic [NCH-1:0]   dtrig_trig;
    logic             scan_busy;
    logic             scan_done;
    logic             scan_err;

    dtrig_threshold_scan_if #(.NCH(NCH)) bus ();

    dtrig_threshold_scan #(
        .NCH         (NCH),
        .SETTLE_MS   (2),
        .DAC_TIMEOUT (300)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .msec           (msec),
        .scan_start     (scan_start),
        .scan_abort     (scan_abort),
        .thr_start      (thr_start),
        .thr_stop       (thr_stop),
        .thr_step       (thr_step),
        .scan_window_ms (scan_window_ms),
        .thr_manual     (thr_manual),
        .dtrig_trig     (dtrig_trig),
        .scan_busy      (scan_busy),
        .scan_done      (scan_done),
        .scan_err       (scan_err),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    exp_t             res_q[$];
    logic [8*NCH-1:0] load_q[$];
    int               tests_run    = 0;
    int               tests_failed = 0;
    int               msec_period  = 20;
    int               ms_cnt       = 0;
    int               cyc          = 0;
    int               trig_period [NCH];
    int               exp_lo [NCH];
    int               exp_hi [NCH];
    bit               ack_en       = 1'b1;
    bit               stall_en     = 1'b0;
    bit               stall_done   = 1'b0;
    int               ack_cnt      = 0;
    int               rel_cnt      = 0;
    int               loads_seen   = 0;
    int               res_popped   = 0;
    logic             prev_req     = 1'b0;
    logic [8*NCH-1:0] exp_load;
    exp_t             exp_res;
    int               vcyc;
    int               base;
    int               n;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        tests_run++;
        if (act < lo || act > hi) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Queue expected loads/results for one scan, then pulse scan_start
    task automatic applyStimulus(input logic [7:0] start, input logic [7:0] stop,
                                 input logic [7:0] step, input logic [15:0] win,
                                 input int n_load, input int n_res, input bit restore);
        logic [7:0] t;
        for (int k = 0; k < n_load; k++) begin
            t = start + 8'(k) * step;
            load_q.push_back({NCH{t}});
        end
        if (restore) load_q.push_back(thr_manual);
        for (int k = 0; k < n_res; k++) begin
            t = start + 8'(k) * step;
            for (int c = 0; c < NCH; c++) begin
                res_q.push_back('{thr: t, ch: 3'(c), lo: exp_lo[c], hi: exp_hi[c]});
            end
        end
        @(posedge clk); #1;
        thr_start      = start;
        thr_stop       = stop;
        thr_step       = step;
        scan_window_ms = win;
        scan_start     = 1'b1;
        @(posedge clk); #1;
        scan_start     = 1'b0;
    endtask

    // Bounded wait for scan_done, counting any result cycles on the way
    task automatic waitDone(input int limit, output int valid_cycles);
        int k = 0;
        valid_cycles = 0;
        while (scan_done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
            if (bus.res_valid === 1'b1) valid_cycles++;
        end
        checkOutput("scan_done_seen", 64'(scan_done), 64'd1);
        @(negedge clk);
        checkOutput("scan_busy_after_done", 64'(scan_busy), 64'd0);
    endtask

    task automatic setTriggers(input int ch, input int period, input int lo, input int hi);
        for (int c = 0; c < NCH; c++) begin
            trig_period[c] = 0;
            exp_lo[c]      = 0;
            exp_hi[c]      = 0;
        end
        if (ch >= 0) begin
            trig_period[ch] = period;
            exp_lo[ch]      = lo;
            exp_hi[ch]      = hi;
        end
    endtask

    // 1 ms tick generator with adjustable period
    initial begin
        msec = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ms_cnt >= msec_period - 1) begin
                msec   = 1'b1;
                ms_cnt = 0;
            end else begin
                msec   = 1'b0;
                ms_cnt = ms_cnt + 1;
            end
        end
    end

    // Periodic single-cycle trigger pulses per channel
    initial begin
        dtrig_trig = '0;
        forever begin
            @(posedge clk); #1;
            cyc = cyc + 1;
            for (int i = 0; i < NCH; i++) begin
                dtrig_trig[i] = (trig_period[i] != 0) && ((cyc % trig_period[i]) == 0);
            end
        end
    end

    // DAC loader model: ack 5 cycles after request, release 2 cycles after drop
    initial begin
        bus.command_dacset_finish = 1'b0;
        bus.dtrig_en              = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bus.command_dacset) begin
                rel_cnt = 0;
                if (ack_en && !bus.command_dacset_finish) begin
                    if (ack_cnt == 4) bus.command_dacset_finish = 1'b1;
                    else ack_cnt = ack_cnt + 1;
                end
            end else begin
                ack_cnt = 0;
                if (bus.command_dacset_finish) begin
                    if (rel_cnt == 1) begin
                        bus.command_dacset_finish = 1'b0;
                        rel_cnt = 0;
                    end else begin
                        rel_cnt = rel_cnt + 1;
                    end
                end
            end
        end
    end

    // Load monitor: each new DAC request must carry the next expected thresholds
    initial begin
        forever begin
            @(negedge clk);
            if (bus.command_dacset && !prev_req) begin
                if (load_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_load: got %0h, expected no request", bus.dtrig_threshold);
                end else begin
                    exp_load = load_q.pop_front();
                    checkOutput("dac_load_thr", 64'(bus.dtrig_threshold), 64'(exp_load));
                end
                loads_seen = loads_seen + 1;
            end
            prev_req = bus.command_dacset;
        end
    end

    // Result monitor: every accepted result is compared against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
                res_popped = res_popped + 1;
                if (res_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_result: got ch %0d thr %0d, expected none", bus.res_ch, bus.res_thr);
                end else begin
                    exp_res = res_q.pop_front();
                    checkOutput("res_thr", 64'(bus.res_thr), 64'(exp_res.thr));
                    checkOutput("res_ch", 64'(bus.res_ch), 64'(exp_res.ch));
                    checkRange("res_count", int'(bus.res_count), exp_res.lo, exp_res.hi);
                end
            end
        end
    end

    // Back-pressure: hold res_ready low 50 cycles once ch2 is presented
    initial begin
        bus.res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_en && !stall_done && bus.res_valid && bus.res_ch == 3'd2) begin
                bus.res_ready = 1'b0;
                repeat (50) begin
                    @(negedge clk);
                    checkOutput("stall_valid", 64'(bus.res_valid), 64'd1);
                    checkOutput("stall_thr", 64'(bus.res_thr), 64'd77);
                    checkOutput("stall_ch", 64'(bus.res_ch), 64'd2);
                    checkRange("stall_count", int'(bus.res_count), 3, 4);
                end
                @(posedge clk); #1;
                bus.res_ready = 1'b1;
                @(posedge clk); #1;
                checkOutput("after_accept_valid", 64'(bus.res_valid), 64'd1);
                checkOutput("after_accept_ch", 64'(bus.res_ch), 64'd3);
                stall_done = 1'b1;
            end
        end
    end

    // Main directed sequence
    initial begin
        rst            = 1'b1;
        scan_start     = 1'b0;
        scan_abort     = 1'b0;
        thr_start      = 8'd0;
        thr_stop       = 8'd0;
        thr_step       = 8'd0;
        scan_window_ms = 16'd0;
        thr_manual     = 56'h11223344556677;
        setTriggers(-1, 0, 0, 0);

        repeat (3) @(negedge clk);
        checkOutput("rst_threshold", 64'(bus.dtrig_threshold), 64'h11223344556677);
        checkOutput("rst_dacset", 64'(bus.command_dacset), 64'd0);
        checkOutput("rst_res_valid", 64'(bus.res_valid), 64'd0);
        checkOutput("rst_busy", 64'(scan_busy), 64'd0);
        checkOutput("rst_done", 64'(scan_done), 64'd0);
        checkOutput("rst_err", 64'(scan_err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] scan 10..30 step 10, window 2");
        msec_period = 20;
        base = res_popped;
        applyStimulus(8'd10, 8'd30, 8'd10, 16'd2, 3, 3, 1'b1);
        waitDone(5000, vcyc);
        checkOutput("scan1_results", 64'(res_popped - base), 64'd21);
        checkOutput("scan1_loads_left", 64'(load_q.size()), 64'd0);
        checkOutput("idle_threshold", 64'(bus.dtrig_threshold), 64'h11223344556677);

        $display("[TB] ch3 every 4 cycles, 400-cycle msec, window 1");
        msec_period = 400;
        setTriggers(3, 4, 99, 101);
        applyStimulus(8'd40, 8'd40, 8'd5, 16'd1, 1, 1, 1'b1);
        waitDone(5000, vcyc);

        $display("[TB] start 250 stop 255 step 10");
        msec_period = 20;
        setTriggers(-1, 0, 0, 0);
        base = res_popped;
        applyStimulus(8'd250, 8'd255, 8'd10, 16'd0, 1, 1, 1'b1);
        waitDone(2000, vcyc);
        checkOutput("overflow_results", 64'(res_popped - base), 64'd7);

        $display("[TB] ch2 back-pressure");
        setTriggers(2, 5, 3, 4);
        stall_en = 1'b1;
        applyStimulus(8'd77, 8'd80, 8'd10, 16'd1, 1, 1, 1'b1);
        waitDone(2000, vcyc);
        checkOutput("stall_exercised", 64'(stall_done), 64'd1);
        stall_en = 1'b0;

        $display("[TB] abort during COUNT of step 2");
        setTriggers(-1, 0, 0, 0);
        base = loads_seen;
        applyStimulus(8'd10, 8'd30, 8'd10, 16'd5, 2, 1, 1'b1);
        n = 0;
        while ((loads_seen < base + 2 || bus.command_dacset) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_reached_step2", 64'(loads_seen - base), 64'd2);
        repeat (70) @(posedge clk);
        #1 scan_abort = 1'b1;
        @(posedge clk); #1;
        scan_abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_res_valid", 64'(bus.res_valid), 64'd0);
        waitDone(2000, vcyc);
        checkOutput("abort_valid_cycles", 64'(vcyc), 64'd0);
        checkOutput("abort_loads_left", 64'(load_q.size()), 64'd0);
        checkOutput("abort_results_left", 64'(res_q.size()), 64'd0);

`ifdef DTRIG_SCAN_TIMEOUT_EN
        $display("[TB] DAC timeout with no ack");
        ack_en = 1'b0;
        applyStimulus(8'd60, 8'd60, 8'd1, 16'd1, 1, 0, 1'b0);
        waitDone(2000, vcyc);
        checkOutput("timeout_err", 64'(scan_err), 64'd1);
        ack_en = 1'b1;
`else
        checkOutput("err_tied_low", 64'(scan_err), 64'd0);
`endif

        $display("[TB] ch0 every cycle, window 1000 ms, saturation");
        msec_period = 66;
        setTriggers(0, 1, 65535, 65535);
        applyStimulus(8'd5, 8'd5, 8'd1, 16'd1000, 1, 1, 1'b1);
        waitDone(80000, vcyc);
        checkOutput("final_loads_left", 64'(load_q.size()), 64'd0);
        checkOutput("final_results_left", 64'(res_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
